// File: rtl/tff_pkg.sv
// Shared encodings and elaboration helpers for the toggle-stage chain.
package tff_pkg;

   // Operating mode of the chain, taken from the 'mode' pin.
   typedef enum logic {
      MODE_CHAIN = 1'b0,
      MODE_COUNT = 1'b1
   } mode_e;

   // Count direction in count mode, taken from the 'dir' pin.
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Larger of two integers, used to keep the tap-select at least one bit wide.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop stage: async active-low reset, then synchronous clear,
// parallel load and toggle, in that order of precedence.
module tff_cell (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic load,
   input  logic d,
   input  logic t,
   output logic q
);

   // Stage register with clear > load > toggle precedence.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= 1'b0;
      end else if (clr) begin
         q <= 1'b0;
      end else if (load) begin
         q <= d;
      end else if (t) begin
         q <= ~q;
      end
   end

endmodule

// File: rtl/tff_chain.sv
// Chain of N toggle stages. In chain mode each stage toggles when the stage
// below it is set (stage 0 toggles on t); in count mode the stages form a
// synchronous up/down binary counter with a registered wrap pulse on tc.
module tff_chain
   import tff_pkg::*;
#(
   parameter  int N  = 4,
   localparam int SW = max_int(1, clog2(N))
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          t,
   input  logic          mode,
   input  logic          dir,
   input  logic          clr,
   input  logic          load,
   input  logic [N-1:0]  load_val,
   input  logic [SW-1:0] sel,
   output logic [N-1:0]  s,
   output logic          q,
   output logic          tc
);

   mode_e        cur_mode;
   dir_e         cur_dir;
   logic [N-1:0] en;
   logic [N-1:0] ones_below;
   logic [N-1:0] zeros_below;
   logic         wrap;
   logic         tc_q;

   assign cur_mode = mode_e'(mode);
   assign cur_dir  = dir_e'(dir);

   // Prefix conditions: every stage below i is one / every stage below i is zero.
   always_comb begin
      logic run_ones;
      logic run_zeros;
      ones_below  = '0;
      zeros_below = '0;
      run_ones    = 1'b1;
      run_zeros   = 1'b1;
      for (int i = 0; i < N; i++) begin
         ones_below[i]  = run_ones;
         zeros_below[i] = run_zeros;
         run_ones       = run_ones & s[i];
         run_zeros      = run_zeros & ~s[i];
      end
   end

   // Per-stage toggle enables; all are derived from pre-edge state.
   always_comb begin
      en = '0;
      if (cur_mode == MODE_CHAIN) begin
         en[0] = t;
         for (int i = 1; i < N; i++) begin
            en[i] = s[i-1];
         end
      end else if (cur_dir == DIR_UP) begin
         en = {N{t}} & ones_below;
      end else begin
         en = {N{t}} & zeros_below;
      end
   end

   // Wrap detection: a counting edge that leaves all-ones going up or all-zeros going down.
   always_comb begin
      wrap = 1'b0;
      if (cur_mode == MODE_COUNT && t) begin
         if (cur_dir == DIR_UP) begin
            wrap = &s;
         end else begin
            wrap = ~|s;
         end
      end
   end

   // Registered terminal-count pulse; clear and load suppress it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tc_q <= 1'b0;
      end else if (clr || load) begin
         tc_q <= 1'b0;
      end else begin
         tc_q <= wrap;
      end
   end

   // A pulse left over from count mode is hidden once chain mode is selected.
   assign tc = tc_q & (cur_mode == MODE_COUNT);

   // One T flip-flop per stage.
   for (genvar g = 0; g < N; g++) begin : g_stage
      tff_cell u_cell (
         .clk  (clk),
         .rst  (rst),
         .clr  (clr),
         .load (load),
         .d    (load_val[g]),
         .t    (en[g]),
         .q    (s[g])
      );
   end

   // Tap select; out-of-range selects read as zero.
   always_comb begin
      q = 1'b0;
      if (32'(sel) < 32'(N)) begin
         q = s[sel];
      end
   end

endmodule

// File: tb/tb_tff_chain.sv
// Directed bench for tff_chain: a 4-stage instance for the main scenarios and
// a 5-stage instance to reach an out-of-range tap select.
module tb_tff_chain;

   logic       clk;
   logic       rst;
   logic       t;
   logic       mode;
   logic       dir;
   logic       clr;
   logic       load;
   logic [3:0] load_val;
   logic [1:0] sel;
   logic [3:0] s;
   logic       q;
   logic       tc;

   logic [4:0] load_val5;
   logic [2:0] sel5;
   logic [4:0] s5;
   logic       q5;
   logic       tc5;

   int n_checks;
   int n_fail;

   tff_chain #(.N(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .t        (t),
      .mode     (mode),
      .dir      (dir),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .sel      (sel),
      .s        (s),
      .q        (q),
      .tc       (tc)
   );

   tff_chain #(.N(5)) dut5 (
      .clk      (clk),
      .rst      (rst),
      .t        (t),
      .mode     (mode),
      .dir      (dir),
      .clr      (clr),
      .load     (load),
      .load_val (load_val5),
      .sel      (sel5),
      .s        (s5),
      .q        (q5),
      .tc       (tc5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; t = 1'b0; mode = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0;
      load_val = 4'b0000; sel = 2'd0; load_val5 = 5'b00000; sel5 = 3'd0;
      step();
      step();
      n_checks++;
      if (s !== 4'b0000) begin
         n_fail++; $display("FAIL reset_s: got %b expected 0000", s);
      end
      n_checks++;
      if (tc !== 1'b0) begin
         n_fail++; $display("FAIL reset_tc: got %b expected 0", tc);
      end
      n_checks++;
      if (q !== 1'b0) begin
         n_fail++; $display("FAIL reset_q: got %b expected 0", q);
      end
      rst = 1'b1;
   endtask

   task automatic test_chain();
      logic [3:0] exp_s[4];
      exp_s[0] = 4'b0001; exp_s[1] = 4'b0011; exp_s[2] = 4'b0101; exp_s[3] = 4'b1111;
      mode = 1'b0; t = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         t = 1'b0;
         n_checks++;
         if (s !== exp_s[i]) begin
            n_fail++; $display("FAIL chain_s[%0d]: got %b expected %b", i, s, exp_s[i]);
         end
         n_checks++;
         if (tc !== 1'b0) begin
            n_fail++; $display("FAIL chain_tc[%0d]: got %b expected 0", i, tc);
         end
      end
   endtask

   task automatic test_count_up();
      logic [3:0] exp_s;
      clr = 1'b1;
      step();
      clr = 1'b0;
      n_checks++;
      if (s !== 4'b0000) begin
         n_fail++; $display("FAIL up_clr: got %b expected 0000", s);
      end
      mode = 1'b1; dir = 1'b0; t = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         exp_s = 4'(i % 16);
         n_checks++;
         if (s !== exp_s) begin
            n_fail++; $display("FAIL up_s[%0d]: got %b expected %b", i, s, exp_s);
         end
         n_checks++;
         if (tc !== (i == 16)) begin
            n_fail++; $display("FAIL up_tc[%0d]: got %b expected %b", i, tc, (i == 16));
         end
      end
      t = 1'b0;
      step();
      n_checks++;
      if (tc !== 1'b0 || s !== 4'b0000) begin
         n_fail++; $display("FAIL up_hold: got s=%b tc=%b expected s=0000 tc=0", s, tc);
      end
   endtask

   task automatic test_count_down();
      logic [3:0] exp_s[4];
      logic       exp_tc[4];
      exp_s[0] = 4'b0010; exp_s[1] = 4'b0001; exp_s[2] = 4'b0000; exp_s[3] = 4'b1111;
      exp_tc[0] = 1'b0; exp_tc[1] = 1'b0; exp_tc[2] = 1'b0; exp_tc[3] = 1'b1;
      load = 1'b1; load_val = 4'b0011;
      step();
      load = 1'b0;
      n_checks++;
      if (s !== 4'b0011 || tc !== 1'b0) begin
         n_fail++; $display("FAIL down_load: got s=%b tc=%b expected s=0011 tc=0", s, tc);
      end
      mode = 1'b1; dir = 1'b1; t = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (s !== exp_s[i]) begin
            n_fail++; $display("FAIL down_s[%0d]: got %b expected %b", i, s, exp_s[i]);
         end
         n_checks++;
         if (tc !== exp_tc[i]) begin
            n_fail++; $display("FAIL down_tc[%0d]: got %b expected %b", i, tc, exp_tc[i]);
         end
      end
      t = 1'b0;
      step();
      n_checks++;
      if (s !== 4'b1111 || tc !== 1'b0) begin
         n_fail++; $display("FAIL down_hold: got s=%b tc=%b expected s=1111 tc=0", s, tc);
      end
      dir = 1'b0;
   endtask

   task automatic test_priority();
      load = 1'b1; load_val = 4'b0101;
      step();
      n_checks++;
      if (s !== 4'b0101) begin
         n_fail++; $display("FAIL prio_preload: got %b expected 0101", s);
      end
      clr = 1'b1; load = 1'b1; load_val = 4'b1010; t = 1'b1; mode = 1'b1;
      step();
      n_checks++;
      if (s !== 4'b0000 || tc !== 1'b0) begin
         n_fail++; $display("FAIL prio_clr: got s=%b tc=%b expected s=0000 tc=0", s, tc);
      end
      clr = 1'b0;
      step();
      load = 1'b0; t = 1'b0;
      n_checks++;
      if (s !== 4'b1010 || tc !== 1'b0) begin
         n_fail++; $display("FAIL prio_load: got s=%b tc=%b expected s=1010 tc=0", s, tc);
      end
   endtask

   task automatic test_async_reset();
      mode = 1'b1; dir = 1'b0;
      load = 1'b1; load_val = 4'b0101;
      step();
      load = 1'b0; t = 1'b1;
      step();
      n_checks++;
      if (s !== 4'b0110) begin
         n_fail++; $display("FAIL arst_setup: got %b expected 0110", s);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (s !== 4'b0000 || tc !== 1'b0) begin
         n_fail++; $display("FAIL arst_mid: got s=%b tc=%b expected s=0000 tc=0", s, tc);
      end
      rst = 1'b1;
      step();
      n_checks++;
      if (s !== 4'b0001) begin
         n_fail++; $display("FAIL arst_resume: got %b expected 0001", s);
      end
      // Reset arriving while the wrap pulse is high must drop it at once.
      t = 1'b0; load = 1'b1; load_val = 4'b1111;
      step();
      load = 1'b0; t = 1'b1;
      step();
      t = 1'b0;
      n_checks++;
      if (s !== 4'b0000 || tc !== 1'b1) begin
         n_fail++; $display("FAIL arst_wrap: got s=%b tc=%b expected s=0000 tc=1", s, tc);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (tc !== 1'b0) begin
         n_fail++; $display("FAIL arst_tc: got %b expected 0", tc);
      end
      rst = 1'b1;
   endtask

   task automatic test_tap_select();
      logic [4:0] cnt;
      clr = 1'b1;
      step();
      clr = 1'b0;
      mode = 1'b1; dir = 1'b0; t = 1'b1;
      sel = 2'd2; sel5 = 3'd5;
      cnt = 5'd0;
      for (int i = 0; i < 10; i++) begin
         step();
         cnt = cnt + 5'd1;
         n_checks++;
         if (q !== cnt[2]) begin
            n_fail++; $display("FAIL tap_sel2[%0d]: got %b expected %b", i, q, cnt[2]);
         end
         n_checks++;
         if (q5 !== 1'b0) begin
            n_fail++; $display("FAIL tap_sel5[%0d]: got %b expected 0", i, q5);
         end
         n_checks++;
         if (s5 !== cnt) begin
            n_fail++; $display("FAIL tap_s5[%0d]: got %b expected %b", i, s5, cnt);
         end
      end
      t = 1'b0;
      sel = 2'd3; sel5 = 3'd3;
      #1;
      n_checks++;
      if (q !== cnt[3] || q5 !== cnt[3]) begin
         n_fail++; $display("FAIL tap_sel3: got q=%b q5=%b expected %b", q, q5, cnt[3]);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_chain();
      test_count_up();
      test_count_down();
      test_priority();
      test_async_reset();
      test_tap_select();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tff_chain.md
TFF_CHAIN -- requirements
Module: tff_chain

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of toggle stages; legal range 2..32.
REQ-002 SHALL have parameter SW, default max(1, clog2(N)), meaning tap-select width; derived, not overridden.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port t  input  1  toggle enable for stage 0, and count enable in count mode.
REQ-006 SHALL have port mode  input  1  0 = chain mode, 1 = count mode.
REQ-007 SHALL have port dir  input  1  count direction in count mode: 0 = up, 1 = down; ignored in chain mode.
REQ-008 SHALL have port clr  input  1  synchronous clear of all state.
REQ-009 SHALL have port load  input  1  synchronous parallel load.
REQ-010 SHALL have port load_val  input  N  value taken by s on load.
REQ-011 SHALL have port sel  input  SW  tap select for q.
REQ-012 SHALL have port s  output  N  stage state vector, bit 0 = stage 0.
REQ-013 SHALL have port q  output  1  selected stage, s[sel].
REQ-014 SHALL have port tc  output  1  registered terminal-count pulse.

Function
REQ-015 SHALL apply per-edge priority as follows: clr, then load, then toggle rules; the losing actions have no effect.
REQ-016 SHALL, on clr, set s to 0 and tc to 0 at the next edge.
REQ-017 SHALL, on load with clr low, set s to load_val and tc to 0 at the next edge.
REQ-018 SHALL, in chain mode, toggle s[0] iff t=1.
REQ-019 SHALL, in chain mode, toggle s[i] (i>=1) iff pre-edge s[i-1]=1, independent of t.
REQ-020 SHALL, in count mode with dir=0, toggle s[i] iff t=1 and all pre-edge s[j<i] are 1; s increments mod 2^N.
REQ-021 SHALL, in count mode with dir=1, toggle s[i] iff t=1 and all pre-edge s[j<i] are 0; s decrements mod 2^N.
REQ-022 SHALL hold s when no rule toggles a stage.
REQ-023 SHALL drive tc high for exactly the one cycle following an edge at which, in count mode with t=1 and no clr/load, s wrapped (up: all-ones to 0; down: 0 to all-ones); tc SHALL otherwise be 0.
REQ-024 SHALL drive tc at 0 at all times in chain mode.
REQ-025 SHALL drive q combinationally as s[sel] when sel<N and as 0 when sel>=N.
REQ-026 SHALL apply a change of mode or dir from the next edge, retaining s; no wrap is inferred from a mode change.
REQ-027 SHALL update s in the same edge as the enabling inputs, with 0 cycles of latency beyond the register.

Reset
REQ-028 SHALL, while rst=0, force s=0 and tc=0 immediately, without a clock edge, including mid-count.
REQ-029 SHALL apply normal rules from the first rising clk edge after rst deasserts.

Structure
REQ-030 SHALL place mode encodings (CHAIN=0, COUNT=1), direction encodings (UP=0, DOWN=1), and the clog2 width function in shared package tff_pkg.
REQ-031 SHALL use one sub-module, tff_cell: a single T flip-flop with async active-low reset, sync clear, sync load, and a toggle input; instantiated N times.
REQ-032 SHALL compute per-stage toggle enables and tc in tff_chain.

Verification (N=4)
REQ-033 SHALL cover chain mode: reset, mode=0, t=1 for one cycle then t=0 -> s = 0001, 0011, 0101, 1111 on successive edges; tc stays 0.
REQ-034 SHALL cover count up: mode=1, dir=0, t=1 for 16 cycles from 0 -> s = 1..15, 0; tc high exactly one cycle, the cycle after s becomes 0.
REQ-035 SHALL cover count down: load_val=0011 loaded, then dir=1, t=1 -> s = 0010, 0001, 0000, 1111; tc pulses once, after 1111 appears.
REQ-036 SHALL cover priority: s=0101, clr=1, load=1, load_val=1010, t=1 -> s=0000, tc=0; then clr=0 with load=1 -> s=1010.
REQ-037 SHALL cover async reset: with count running at s=0110, drop rst between edges -> s=0000 and tc=0 before the next edge.
REQ-038 SHALL cover tap select: sel=2 -> q tracks s[2] every cycle; sel=5 -> q=0.
